// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller slice.
// FSM encoding, IRQ codes, default vector layout and helpers.
package cpu_pkg;

   localparam int N_IRQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OFFER   = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   localparam logic [2:0] IRQ_NONE = 3'b000;
   localparam logic [2:0] IRQ_L0   = 3'b001;
   localparam logic [2:0] IRQ_L1   = 3'b010;
   localparam logic [2:0] IRQ_L2   = 3'b011;
   localparam logic [2:0] IRQ_L3   = 3'b100;

   localparam logic [9:0] VEC_BASE_DEF   = 10'b1101100000;
   localparam int         VEC_STRIDE_DEF = 8;

   // Fixed priority: lowest set index wins.
   function automatic logic [1:0] prio_sel(input logic [3:0] req);
      logic [1:0] idx;
      idx = 2'd0;
      priority case (1'b1)
         req[0]:  idx = 2'd0;
         req[1]:  idx = 2'd1;
         req[2]:  idx = 2'd2;
         req[3]:  idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Line index to the code presented to the CPU.
   function automatic logic [2:0] irq_code(input logic [1:0] idx);
      logic [2:0] code;
      code = IRQ_NONE;
      unique case (idx)
         2'd0: code = IRQ_L0;
         2'd1: code = IRQ_L1;
         2'd2: code = IRQ_L2;
         2'd3: code = IRQ_L3;
      endcase
      return code;
   endfunction

   // Vector address of a line.
   function automatic logic [9:0] vec_addr(
      input logic [9:0] base,
      input int         stride,
      input logic [1:0] idx
   );
      return base + 10'(stride * int'(idx));
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side bundle of the interrupt controller.
// master = CPU, slave = controller.
interface irq_ctrl_if;

   logic       e_interrupt;
   logic       wcalli;
   logic       pop_inm;
   logic       we_mask;
   logic [3:0] mask_d;

   logic [2:0] ir_attended;
   logic [9:0] dir_sal_in;
   logic       in_service;
   logic [3:0] pending;
   logic [7:0] irq_count;

   modport master (
      output e_interrupt, wcalli, pop_inm, we_mask, mask_d,
      input  ir_attended, dir_sal_in, in_service, pending, irq_count
   );

   modport slave (
      input  e_interrupt, wcalli, pop_inm, we_mask, mask_d,
      output ir_attended, dir_sal_in, in_service, pending, irq_count
   );

endinterface

// File: rtl/irq_sync.sv
// Per-line synchronizer and rising-edge detector.
// Two sync flops feed a history flop; rise = sync2 & ~hist.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic hist;

   // shift the async line through sync1 -> sync2 -> hist
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= irq;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign rise = sync2 & ~hist;

endmodule

// File: rtl/irq_ctrl.sv
// Four-line fixed-priority interrupt controller.
// Offers one line at a time and holds it until popped.
module irq_ctrl
   import cpu_pkg::*;
#(
   parameter logic [9:0] VEC_BASE   = VEC_BASE_DEF,
   parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    irq_in,
   irq_ctrl_if.slave     bus
);

   irq_state_t state;
   irq_state_t state_nx;

   logic [1:0] sel;
   logic [1:0] sel_nx;
   logic [3:0] pend;
   logic [3:0] mask;
   logic [7:0] count;

   logic [3:0] rise;
   logic [3:0] armed;
   logic [3:0] clr;
   logic       accept;
   logic [2:0] code;
   logic [9:0] vec;
   logic       busy;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
      irq_sync u_sync (
         .clk   (clk),
         .reset (reset),
         .irq   (irq_in[i]),
         .rise  (rise[i])
      );
   end

   assign armed = pend & mask;
   assign clr   = accept ? (4'b0001 << sel) : 4'b0000;

   // next-state logic and per-state outputs
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      accept   = 1'b0;
      code     = IRQ_NONE;
      vec      = '0;
      busy     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.e_interrupt && (|armed)) begin
               state_nx = ST_OFFER;
               sel_nx   = prio_sel(armed);
            end
         end
         ST_OFFER: begin
            code = irq_code(sel);
            vec  = vec_addr(VEC_BASE, VEC_STRIDE, sel);
            if (bus.wcalli) begin
               accept   = 1'b1;
               state_nx = ST_SERVICE;
            end else if (!bus.e_interrupt) begin
               state_nx = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            busy = 1'b1;
            vec  = vec_addr(VEC_BASE, VEC_STRIDE, sel);
            if (bus.pop_inm) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // state and frozen selection registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         sel   <= 2'd0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
      end
   end

   // pending latch: a new edge wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= 4'b0000;
      end else begin
         pend <= (pend & ~clr) | rise;
      end
   end

   // mask register, writable in any state
   always_ff @(posedge clk) begin
      if (reset) begin
         mask <= 4'b1111;
      end else if (bus.we_mask) begin
         mask <= bus.mask_d;
      end
   end

   // saturating count of accepted interrupts
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 8'h00;
      end else if (accept && (count != 8'hFF)) begin
         count <= count + 8'h01;
      end
   end

   assign bus.ir_attended = code;
   assign bus.dir_sal_in  = vec;
   assign bus.in_service  = busy;
   assign bus.pending     = pend;
   assign bus.irq_count   = count;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_irq_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] irq_in;

   irq_ctrl_if bus ();

   irq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .irq_in (irq_in),
      .bus    (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model: sample history, pending set, mode flags
   logic [3:0] m_h0, m_h1, m_h2;
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   int         m_cnt;
   bit         m_offer;
   bit         m_serv;
   int         m_sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [3:0] edges;
      logic [3:0] act;
      logic [3:0] clr;
      if (reset) begin
         m_h0 = 0; m_h1 = 0; m_h2 = 0;
         m_pend = 0; m_mask = 4'hF; m_cnt = 0;
         m_offer = 0; m_serv = 0; m_sel = 0;
         return;
      end
      edges = m_h1 & ~m_h2;
      act   = m_pend & m_mask;
      clr   = 4'b0000;
      if (!m_offer && !m_serv) begin
         if (bus.e_interrupt && act != 0) begin
            m_offer = 1;
            m_sel = 3;
            for (int i = 3; i >= 0; i--)
               if (act[i]) m_sel = i;
         end
      end else if (m_offer) begin
         if (bus.wcalli) begin
            clr[m_sel] = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_offer = 0;
            m_serv = 1;
         end else if (!bus.e_interrupt) begin
            m_offer = 0;
         end
      end else if (bus.pop_inm) begin
         m_serv = 0;
      end
      m_pend = (m_pend & ~clr) | edges;
      if (bus.we_mask) m_mask = bus.mask_d;
      m_h2 = m_h1;
      m_h1 = m_h0;
      m_h0 = irq_in;
   endtask

   task automatic check_all();
      int code;
      int vec;
      code = m_offer ? m_sel + 1 : 0;
      vec  = (m_offer || m_serv) ? 864 + 8 * m_sel : 0;
      chk("model ir_attended", 32'(bus.ir_attended), 32'(code));
      chk("model dir_sal_in", 32'(bus.dir_sal_in), 32'(vec));
      chk("model in_service", 32'(bus.in_service), 32'(m_serv));
      chk("model pending", 32'(bus.pending), 32'(m_pend));
      chk("model irq_count", 32'(bus.irq_count), 32'(m_cnt));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wait_offer(input string tag, input logic [2:0] code);
      int n = 0;
      while (bus.ir_attended == 3'b000 && n < 10) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.ir_attended), 32'(code));
   endtask

   task automatic accept_pop();
      bus.wcalli = 1; step(); bus.wcalli = 0;
      bus.pop_inm = 1; step(); bus.pop_inm = 0;
   endtask

   initial begin
      reset = 1; irq_in = 0;
      bus.e_interrupt = 0; bus.wcalli = 0; bus.pop_inm = 0;
      bus.we_mask = 0; bus.mask_d = 0;
      step(); step();
      chk("reset ir", 32'(bus.ir_attended), 32'd0);
      chk("reset count", 32'(bus.irq_count), 32'd0);
      reset = 0;

      // line 2 pulse: pending after edge 3, offer after edge 4
      bus.e_interrupt = 1;
      irq_in = 4'b0100; step(); irq_in = 0;
      chk("l2 pend e1", 32'(bus.pending), 32'd0);
      step();
      chk("l2 pend e2", 32'(bus.pending), 32'd0);
      step();
      chk("l2 pend e3", 32'(bus.pending), 32'b0100);
      chk("l2 no offer e3", 32'(bus.ir_attended), 32'd0);
      step();
      chk("l2 offer e4", 32'(bus.ir_attended), 32'b011);
      chk("l2 vector e4", 32'(bus.dir_sal_in), 32'b1101110000);
      bus.wcalli = 1; step(); bus.wcalli = 0;
      chk("l2 service", 32'(bus.in_service), 32'd1);
      chk("l2 svc vector", 32'(bus.dir_sal_in), 32'b1101110000);
      bus.pop_inm = 1; step(); bus.pop_inm = 0;

      // lines 1 and 3 together: priority then immediate re-offer
      irq_in = 4'b1010; step(); step(); irq_in = 0;
      wait_offer("l1 first", 3'b010);
      accept_pop();
      step();
      chk("l3 re-offer", 32'(bus.ir_attended), 32'b100);
      accept_pop();
      chk("count after 3", 32'(bus.irq_count), 32'd3);

      // masked line stays pending, offered after unmask
      bus.we_mask = 1; bus.mask_d = 4'b1110; step(); bus.we_mask = 0;
      irq_in = 4'b0001; step(); step(); irq_in = 0;
      step(); step(); step(); step();
      chk("masked no offer", 32'(bus.ir_attended), 32'd0);
      chk("masked pending", 32'(bus.pending), 32'b0001);
      bus.we_mask = 1; bus.mask_d = 4'b1111; step(); bus.we_mask = 0;
      chk("unmask edge", 32'(bus.ir_attended), 32'd0);
      step();
      chk("unmask offer", 32'(bus.ir_attended), 32'b001);
      accept_pop();

      // enable drop withdraws offer, pending kept
      irq_in = 4'b0010; step(); step(); irq_in = 0;
      wait_offer("l1 offer", 3'b010);
      bus.e_interrupt = 0; step();
      chk("withdraw ir", 32'(bus.ir_attended), 32'd0);
      chk("withdraw pend", 32'(bus.pending), 32'b0010);
      bus.e_interrupt = 1; step();
      chk("re-enable ir", 32'(bus.ir_attended), 32'b010);
      bus.wcalli = 1; step(); bus.wcalli = 0;

      // reset in service
      irq_in = 4'b1000; step(); step(); irq_in = 0; step();
      bus.we_mask = 1; bus.mask_d = 4'b0110; step(); bus.we_mask = 0;
      chk("pre-rst svc", 32'(bus.in_service), 32'd1);
      chk("pre-rst pend", 32'(bus.pending), 32'b1000);
      reset = 1; step(); reset = 0;
      chk("rst svc", 32'(bus.in_service), 32'd0);
      chk("rst pend", 32'(bus.pending), 32'd0);
      chk("rst count", 32'(bus.irq_count), 32'd0);
      chk("rst dir", 32'(bus.dir_sal_in), 32'd0);
      irq_in = 4'b0001; step(); step(); irq_in = 0;
      wait_offer("rst mask ones", 3'b001);
      accept_pop();

      // random traffic against the model
      for (int k = 0; k < 1500; k++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(3) == 0) irq_in[b] = ~irq_in[b];
         bus.e_interrupt = ($urandom_range(7) != 0);
         bus.wcalli  = ($urandom_range(2) == 0);
         bus.pop_inm = ($urandom_range(2) == 0);
         bus.we_mask = ($urandom_range(15) == 0);
         bus.mask_d  = 4'($urandom);
         reset = ($urandom_range(127) == 0);
         step();
      end
      reset = 0; irq_in = 0; bus.e_interrupt = 1;
      bus.wcalli = 0; bus.pop_inm = 0; bus.we_mask = 0;

      // saturation of the accept counter
      reset = 1; step(); reset = 0;
      for (int k = 1; k <= 256; k++) begin
         irq_in = 4'b0001; step(); irq_in = 0; step();
         wait_offer("sat offer", 3'b001);
         accept_pop();
         if (k == 255)
            chk("count 255", 32'(bus.irq_count), 32'hFF);
      end
      chk("count saturated", 32'(bus.irq_count), 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 10'b1101100000, SHALL be the vector address of IRQ line 0.
REQ-002 Parameter VEC_STRIDE, default 8, SHALL be the address distance between consecutive line vectors.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq_in  in  4  asynchronous external request lines, rising-edge sensitive.
REQ-006 e_interrupt  in  1  global interrupt enable from the CPU.
REQ-007 wcalli  in  1  CPU acceptance strobe: interrupt push executed this cycle.
REQ-008 pop_inm  in  1  CPU return-from-interrupt strobe.
REQ-009 we_mask  in  1  mask register write strobe.
REQ-010 mask_d  in  4  new mask value; bit=1 enables the line.
REQ-011 ir_attended  out  3  code of the offered interrupt; 3'b000 none, 3'b001..3'b100 = lines 0..3.
REQ-012 dir_sal_in  out  10  vector address of the offered or serviced line.
REQ-013 in_service  out  1  high while an ISR is running.
REQ-014 pending  out  4  latched pending requests.
REQ-015 irq_count  out  8  saturating count of accepted interrupts.

Function
REQ-016 Each irq_in bit SHALL pass a 2-flop synchronizer plus 1 history flop; a rising edge is sync2 & ~hist.
REQ-017 A detected edge SHALL set pending[i] on the next clock, so pending[i] is visible after the 3rd edge sampling irq_in[i] high.
REQ-018 Pending bits SHALL be set regardless of mask; arbitration SHALL consider only pending & mask.
REQ-019 Priority SHALL be fixed, line 0 highest.
REQ-020 FSM states SHALL be IDLE, OFFER and SERVICE.
REQ-021 In IDLE: if e_interrupt=1 and (pending & mask)!=0, go to OFFER and register the winning index sel.
REQ-022 In OFFER: ir_attended = sel+1 and dir_sal_in = VEC_BASE + VEC_STRIDE*sel; otherwise both SHALL be 0 (except dir_sal_in in SERVICE).
REQ-023 In OFFER with wcalli=1: clear pending[sel], increment irq_count (saturate at 255), go to SERVICE.
REQ-024 In OFFER with e_interrupt=0 and wcalli=0: return to IDLE; pending unchanged.
REQ-025 Selection SHALL be frozen during OFFER; a higher-priority arrival waits for the next IDLE.
REQ-026 In SERVICE: in_service=1, dir_sal_in holds the serviced vector, no new offer (non-nesting); pop_inm=1 returns to IDLE.
REQ-027 pop_inm in IDLE or OFFER, or wcalli outside OFFER, SHALL be ignored.
REQ-028 An edge on line sel in the same cycle as its clear SHALL leave pending[sel]=1 (set wins).
REQ-029 we_mask=1 SHALL load mask_d on the next clock in any state; a mask change does not withdraw an active offer.
REQ-030 Minimum re-offer latency: OFFER reached on the clock after returning to IDLE.

Reset
REQ-031 reset=1 SHALL force state IDLE, sync/history flops, pending and irq_count to 0, mask to 4'b1111, sel to 0.
REQ-032 Reset during OFFER or SERVICE SHALL abort immediately; all outputs 0 after that edge.

Structure
REQ-033 State encoding, IRQ code constants and default vector base SHALL reside in shared package cpu_pkg.
REQ-034 The synchronizer plus edge detector SHALL be sub-module irq_sync, instantiated per line.

Verification
REQ-035 Pulse irq_in[2] with e_interrupt=1 -> pending=4'b0100 after edge 3, ir_attended=3'b011, dir_sal_in=10'b1101110000 after edge 4.
REQ-036 Lines 1 and 3 rise together -> offer 3'b010; wcalli, pop_inm -> then offer 3'b100; irq_count=2.
REQ-037 mask=4'b1110, pulse line 0 -> no offer, pending[0]=1; write mask 4'b1111 -> offer 3'b001 on the following cycle.
REQ-038 Offer active, drop e_interrupt -> ir_attended=0 next cycle, pending kept; re-enable -> same offer returns.
REQ-039 Reset asserted in SERVICE -> in_service=0, pending=0, irq_count=0, mask=4'b1111 after one edge.
REQ-040 256 accepted interrupts -> irq_count saturates at 8'hFF.
